mux_4to1_arbiter: RTL and testbench
===================================

Name: mux_4to1_arbiter

Overview:
- Round-robin arbiter that shares the 4:1 one-hot mux datapath between four requesters (a..d).
- Drives the mux's one-hot selects `sel_a`..`sel_d` from registered state, with a matching grant per requester.
- Break-before-make: at least one all-zero select cycle between owners, so the mux never sees overlapping selects.
- Bounded hold time: a requester that keeps its request too long is forcibly released and sent to lowest priority.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may own the mux (legal range 1..255).
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  request from requester a; held high while it needs the mux.
- req_b  input  1  request from requester b.
- req_c  input  1  request from requester c.
- req_d  input  1  request from requester d.
- gnt_a  output  1  grant to requester a (registered).
- gnt_b  output  1  grant to requester b.
- gnt_c  output  1  grant to requester c.
- gnt_d  output  1  grant to requester d.
- sel_a  output  1  mux select for in_a; always equal to gnt_a.
- sel_b  output  1  mux select for in_b; always equal to gnt_b.
- sel_c  output  1  mux select for in_c; always equal to gnt_c.
- sel_d  output  1  mux select for in_d; always equal to gnt_d.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when an owner is forcibly released.

Behaviour:
- Reset (async assert, sync deassert by the reset tree):
  - state=IDLE; all gnt_*/sel_* = 0; busy = 0; timeout = 0; hold_cnt = 0.
  - last_owner = d, so a has highest priority after reset.
- Invariant: gnt/sel vector is one-hot or all-zero in every cycle. Two bits high at once is a design error; the bench asserts this.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - Sample req_*. If any are high, pick the first requester found scanning from last_owner+1 in order a→b→c→d→a.
  - Next edge: state=GRANT; winner's gnt/sel = 1; last_owner = winner; hold_cnt = 1.
  - Latency: req sampled high at edge N gives gnt high after edge N+1 (one cycle).
  - No requests: remain in IDLE.
- GRANT:
  - busy = 1.
  - Each edge with the owner's req high and hold_cnt < MAX_HOLD: hold_cnt increments and the grant holds.
  - Owner req low at an edge: the next edge clears gnt/sel, state=GAP.
  - Owner req high with hold_cnt == MAX_HOLD: forced release. Next edge clears gnt/sel, pulses timeout for one cycle, state=GAP.
  - Requests from non-owners are ignored while in GRANT; no preemption.
- GAP:
  - Exactly one cycle with all selects 0 (break-before-make); busy = 0.
  - Next edge: state=IDLE.
  - Minimum spacing between two different grants is therefore 2 cycles of all-zero select (GAP + IDLE arbitration cycle).
- Fairness:
  - A timed-out owner is last_owner, so it is lowest priority at the next arbitration.
  - With all four requesting continuously, grant order is a,b,c,d,a,...
- Simultaneous events:
  - Owner drops req in the same cycle hold_cnt reaches MAX_HOLD: treated as a normal release, no timeout pulse.
  - New requests during GAP are seen at the following IDLE arbitration.
- Reset mid-grant: all outputs go to 0 immediately (asynchronous), not at the next edge; on release, arbitration restarts with a highest priority.
- MAX_HOLD=1: every grant lasts exactly one cycle. A still-requesting owner gets timeout and re-arbitration.
- hold_cnt saturates and never wraps; its value is only meaningful in GRANT.

Test Plan:
- Reset then single request: rst_n low 3 cycles then high; req_b=1 at edge 5. Required: gnt_b=sel_b=1 from edge 6, busy=1. req_b=0 at edge 9 clears gnt_b at edge 10, one GAP cycle follows, and timeout never pulses.
- All four requesting continuously, MAX_HOLD=8: grants in order a,b,c,d,a. Each lasts 8 cycles with timeout pulsed at each release. Two zero-select cycles separate owners. The one-hot assertion never fires.
- Simultaneous req_a and req_c from IDLE after reset: a wins. After a releases, c wins even though req_a is re-raised.
- Release coincides with the limit: owner drops req on the cycle hold_cnt=MAX_HOLD. Required: normal release with timeout=0.
- Reset during GRANT (owner d, hold_cnt=4): assert rst_n mid-cycle. Required: gnt_d/sel_d/busy go to 0 asynchronously. After release, with req_a and req_d both high, a is granted first.
- MAX_HOLD=1 with req_c held high: pattern gnt_c=1 for 1 cycle, timeout pulse, 2 zero cycles, then gnt_c=1 again, repeating.

Source files
------------

// File: rtl/mux_4to1_arbiter.sv
// -----------------------------------------------------------------------------
// mux_4to1_arbiter
//
// Round-robin arbiter that owns the one-hot selects of a shared 4:1 mux.
// One requester (a..d) at a time is granted the mux. Every hand-over passes
// through a GAP cycle with all selects low and then an IDLE arbitration cycle,
// so the mux never sees two selects high at once. An owner that keeps
// requesting for MAX_HOLD cycles is released, flagged with a one-cycle timeout
// pulse, and becomes lowest priority.
//
// Parameters
//   MAX_HOLD  maximum consecutive cycles one requester may own the mux (1..255)
//   CNT_W     width of the hold counter, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   req_a..req_d   requests, held high while the requester needs the mux
//   gnt_a..gnt_d   registered grants, one-hot or all-zero
//   sel_a..sel_d   mux selects, identical to gnt_a..gnt_d
//   busy           high while a grant is active
//   timeout        one-cycle pulse after an owner is forcibly released
// -----------------------------------------------------------------------------
module mux_4to1_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic req_c,
  input  logic req_d,
  output logic gnt_a,
  output logic gnt_b,
  output logic gnt_c,
  output logic gnt_d,
  output logic sel_a,
  output logic sel_b,
  output logic sel_c,
  output logic sel_d,
  output logic busy,
  output logic timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255 ||
      (CNT_W < 31 && (1 << CNT_W) <= MAX_HOLD)) begin : g_param_check
    $error("mux_4to1_arbiter: MAX_HOLD must be 1..255 and fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  state_t           state,     state_nxt;
  logic [1:0]       owner,     owner_nxt;     // last granted requester
  logic [CNT_W-1:0] hold_cnt,  hold_cnt_nxt;
  logic [3:0]       gnt_q,     gnt_nxt;
  logic             timeout_q, timeout_nxt;

  logic [3:0] req;
  logic       found;
  logic [1:0] winner;

  assign req = {req_d, req_c, req_b, req_a};

  // Round-robin search starting just after the last owner. The 2-bit sum wraps
  // d -> a, and k = 4 lands back on the last owner itself, so it is checked last.
  // NOTE: every signal written in an always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    found  = 1'b0;
    winner = owner;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[owner + 2'(k)]) begin
        found  = 1'b1;
        winner = owner + 2'(k);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    hold_cnt_nxt = hold_cnt;
    gnt_nxt      = '0;
    timeout_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt       = GRANT;
          owner_nxt       = winner;
          hold_cnt_nxt    = CNT_W'(1);
          gnt_nxt[winner] = 1'b1;
        end
      end

      GRANT: begin
        // A dropped request wins over the hold limit: releasing on the limit
        // cycle is a normal release without a timeout pulse.
        if (!req[owner]) begin
          state_nxt = GAP;
        end else if (hold_cnt >= HOLD_LIMIT) begin
          state_nxt   = GAP;
          timeout_nxt = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
          gnt_nxt      = gnt_q;
        end
      end

      GAP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset makes d the last owner so that a has top priority afterwards.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 2'd3;
      hold_cnt  <= '0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      hold_cnt  <= hold_cnt_nxt;
      gnt_q     <= gnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // Grants and selects come straight from flops so the mux never sees a
  // decode glitch; busy is high exactly while a grant flop is set.
  assign {gnt_d, gnt_c, gnt_b, gnt_a} = gnt_q;
  assign {sel_d, sel_c, sel_b, sel_a} = gnt_q;
  assign busy    = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_4to1_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_4to1_arbiter
//
// Two arbiters (MAX_HOLD = 8 and MAX_HOLD = 1) share clock, reset and requests.
// Each edge the driver advances a behavioural model of the arbitration rules
// and queues the expected outputs; a monitor on the falling edge pops and
// compares them, and also logs grant order, grant lengths and timeout pulses
// for the directed checks.
// -----------------------------------------------------------------------------
module tb_mux_4to1_arbiter;

  localparam int HOLD_X = 8;
  localparam int HOLD_Y = 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = '0;

  logic [3:0] gnt_x, sel_x, gnt_y, sel_y;
  logic       busy_x, to_x, busy_y, to_y;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_4to1_arbiter #(.MAX_HOLD(HOLD_X), .CNT_W(8)) u_dut_x (
    .clk(clk), .rst_n(rst_n),
    .req_a(req[0]), .req_b(req[1]), .req_c(req[2]), .req_d(req[3]),
    .gnt_a(gnt_x[0]), .gnt_b(gnt_x[1]), .gnt_c(gnt_x[2]), .gnt_d(gnt_x[3]),
    .sel_a(sel_x[0]), .sel_b(sel_x[1]), .sel_c(sel_x[2]), .sel_d(sel_x[3]),
    .busy(busy_x), .timeout(to_x)
  );

  mux_4to1_arbiter #(.MAX_HOLD(HOLD_Y), .CNT_W(8)) u_dut_y (
    .clk(clk), .rst_n(rst_n),
    .req_a(req[0]), .req_b(req[1]), .req_c(req[2]), .req_d(req[3]),
    .gnt_a(gnt_y[0]), .gnt_b(gnt_y[1]), .gnt_c(gnt_y[2]), .gnt_d(gnt_y[3]),
    .sel_a(sel_y[0]), .sel_b(sel_y[1]), .sel_c(sel_y[2]), .sel_d(sel_y[3]),
    .busy(busy_y), .timeout(to_y)
  );

  // ---------------------------------------------------------------------------
  // Reference model: owner is a requester number or -1; gap counts the
  // mandatory idle edges left before arbitration is allowed again.
  // ---------------------------------------------------------------------------
  int m_owner[2];
  int m_held[2];
  int m_gap[2];
  int m_last[2];
  bit m_to[2];

  logic [5:0] exp_x[$];
  logic [5:0] exp_y[$];

  function automatic int hold_limit(input int i);
    return (i == 0) ? HOLD_X : HOLD_Y;
  endfunction

  function automatic void m_reset(input int i);
    m_owner[i] = -1;
    m_held[i]  = 0;
    m_gap[i]   = 0;
    m_last[i]  = 3;
    m_to[i]    = 1'b0;
  endfunction

  function automatic void m_step(input int i, input logic [3:0] r);
    bit found;
    m_to[i] = 1'b0;
    if (m_owner[i] >= 0) begin
      if (!r[m_owner[i]]) begin
        m_owner[i] = -1;
        m_gap[i]   = 1;
      end else if (m_held[i] == hold_limit(i)) begin
        m_owner[i] = -1;
        m_gap[i]   = 1;
        m_to[i]    = 1'b1;
      end else begin
        m_held[i] = m_held[i] + 1;
      end
    end else if (m_gap[i] > 0) begin
      m_gap[i] = m_gap[i] - 1;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last[i] + k) % 4;
        if (!found && r[c]) begin
          found      = 1'b1;
          m_owner[i] = c;
          m_last[i]  = c;
          m_held[i]  = 1;
        end
      end
    end
  endfunction

  // {grant vector, busy, timeout}
  function automatic logic [5:0] m_out(input int i);
    logic [3:0] g;
    g = '0;
    if (m_owner[i] >= 0) g[m_owner[i]] = 1'b1;
    return {g, m_owner[i] >= 0, m_to[i]};
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 'h%h, expected 'h%h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int         ord_x[$];
  int         ord_y[$];
  int         to_cnt_x = 0;
  int         to_cnt_y = 0;
  int         cur_len_x = 0;
  int         last_len_x = 0;
  logic [3:0] prev_x = '0;
  logic [3:0] prev_y = '0;

  always @(negedge clk) begin
    logic [5:0] e;
    check("onehot_x", 10'($onehot0(gnt_x)), 10'd1);
    check("onehot_y", 10'($onehot0(gnt_y)), 10'd1);
    if (exp_x.size() > 0) begin
      e = exp_x.pop_front();
      check("cycle_x", {gnt_x, sel_x, busy_x, to_x}, {e[5:2], e[5:2], e[1:0]});
    end
    if (exp_y.size() > 0) begin
      e = exp_y.pop_front();
      check("cycle_y", {gnt_y, sel_y, busy_y, to_y}, {e[5:2], e[5:2], e[1:0]});
    end
    if (gnt_x != 4'b0 && prev_x == 4'b0) ord_x.push_back(onehot_idx(gnt_x));
    if (gnt_y != 4'b0 && prev_y == 4'b0) ord_y.push_back(onehot_idx(gnt_y));
    if (to_x) to_cnt_x++;
    if (to_y) to_cnt_y++;
    if (gnt_x != 4'b0) begin
      cur_len_x++;
    end else if (prev_x != 4'b0) begin
      last_len_x = cur_len_x;
      cur_len_x  = 0;
    end
    prev_x = gnt_x;
    prev_y = gnt_y;
  end

  // ---------------------------------------------------------------------------
  // Driver (runs at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) m_reset(i);
      else        m_step(i, r);
    end
    exp_x.push_back(m_out(0));
    exp_y.push_back(m_out(1));
    #1;
  endtask

  // Assert reset mid-cycle and require every output low before the next edge.
  task automatic assert_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_x", {gnt_x, sel_x, busy_x, to_x}, 10'd0);
    check("async_rst_y", {gnt_y, sel_y, busy_y, to_y}, 10'd0);
    exp_x.delete();
    exp_y.delete();
    for (int i = 0; i < 2; i++) m_reset(i);
    exp_x.push_back(m_out(0));
    exp_y.push_back(m_out(1));
  endtask

  task automatic clear_logs();
    ord_x.delete();
    ord_y.delete();
    to_cnt_x = 0;
    to_cnt_y = 0;
  endtask

  task automatic do_reset();
    assert_reset();
    repeat (2) cycle(4'b0000);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic check_order(input string name, input int want[5], input int n);
    check({name, "_count"}, 10'(ord_x.size() >= n), 10'd1);
    for (int k = 0; k < n; k++) begin
      if (k < ord_x.size()) check($sformatf("%s[%0d]", name, k), 10'(ord_x[k]), 10'(want[k]));
    end
  endtask

  initial begin
    int         want[5];
    logic [3:0] r;

    for (int i = 0; i < 2; i++) m_reset(i);
    #2 rst_n = 1'b0;

    // Reset, then a single request from b.
    repeat (3) cycle(4'b0000);
    check("reset_state_x", {gnt_x, sel_x, busy_x, to_x}, 10'd0);
    rst_n = 1'b1;
    cycle(4'b0000);
    clear_logs();
    repeat (4) cycle(4'b0010);
    repeat (5) cycle(4'b0000);
    want = '{1, 0, 0, 0, 0};
    check_order("single_b", want, 1);
    check("single_b_timeouts", 10'(to_cnt_x), 10'd0);

    // All four requesting: a,b,c,d,a with an 8-cycle hold and timeouts.
    do_reset();
    repeat (45) cycle(4'b1111);
    want = '{0, 1, 2, 3, 0};
    check_order("all4", want, 5);
    check("all4_hold_len", 10'(last_len_x), 10'd8);
    check("all4_timeouts", 10'(to_cnt_x), 10'd4);
    repeat (4) cycle(4'b0000);

    // a and c together: a first, then c although a asks again.
    do_reset();
    repeat (3) cycle(4'b0101);
    cycle(4'b0100);
    repeat (6) cycle(4'b0101);
    want = '{0, 2, 0, 0, 0};
    check_order("a_then_c", want, 2);
    repeat (12) cycle(4'b0000);

    // Owner drops its request on the limit cycle: normal release.
    do_reset();
    repeat (8) cycle(4'b0001);
    repeat (4) cycle(4'b0000);
    check("limit_release_len", 10'(last_len_x), 10'd8);
    check("limit_release_timeouts", 10'(to_cnt_x), 10'd0);

    // Reset in the middle of d's grant, then a beats d.
    do_reset();
    repeat (4) cycle(4'b1000);
    check("pre_reset_owner_d", {gnt_x, busy_x}, {4'b1000, 1'b1});
    assert_reset();
    repeat (2) cycle(4'b1001);
    rst_n = 1'b1;
    clear_logs();
    repeat (4) cycle(4'b1001);
    want = '{0, 0, 0, 0, 0};
    check_order("after_rst_a_first", want, 1);
    repeat (12) cycle(4'b0000);

    // MAX_HOLD = 1 with c held: grant, timeout, gap, idle, repeat.
    do_reset();
    repeat (12) cycle(4'b0100);
    repeat (3) cycle(4'b0000);
    check("hold1_timeouts", 10'(to_cnt_y), 10'd4);
    check("hold1_grants", 10'(ord_y.size()), 10'd4);

    // Random request patterns with some persistence.
    do_reset();
    r = '0;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(3) == 0) r[k] = ~r[k];
      end
      cycle(r);
    end
    repeat (4) cycle(4'b0000);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 10'(exp_x.size() + exp_y.size()), 10'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
